// File: rtl/run_controller.sv
// Run controller for the single-cycle core: holds it in reset, releases it for a
// bounded run, and watches the data-memory write port for a pass/stray/timeout verdict.
module run_controller #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned CNT_W        = 16,
    parameter logic [31:0] PASS_ADR     = 32'd100,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADR  = 32'd96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_adr,
    output logic [31:0]      last_data
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_STRAY   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic [1:0]        fc_q, fc_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_en_q, cpu_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            fc_q        <= FC_NONE;
            adr_q       <= '0;
            dat_q       <= '0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            fc_q        <= fc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_en_q    <= cpu_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fc_d    = FC_NONE;
                    adr_d   = '0;
                    dat_d   = '0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                // Pass beats stray beats timeout when they coincide on one edge.
                cnt_d = cnt_q + CNT_W'(1);
                if (MemWrite && DataAdr == PASS_ADR && WriteData == PASS_DATA) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                    fc_d    = FC_NONE;
                    adr_d   = DataAdr;
                    dat_d   = WriteData;
                end else if (MemWrite && DataAdr != SCRATCH_ADR) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                    fc_d    = FC_STRAY;
                    adr_d   = DataAdr;
                    dat_d   = WriteData;
                end else if (cnt_d == CNT_MAX) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                    fc_d    = FC_TIMEOUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies decoded from the next state.
        cpu_reset_d = (state_d == S_IDLE) || (state_d == S_HOLD);
        cpu_en_d    = (state_d == S_RUN);
        busy_d      = (state_d == S_HOLD) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    assign cpu_reset   = cpu_reset_q;
    assign cpu_en      = cpu_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fc_q;
    assign cycle_count = cnt_q;
    assign last_adr    = adr_q;
    assign last_data   = dat_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed and random write programs, each checked
// against a per-cycle write schedule scanned for the first terminating event.
module tb_run_controller;

    localparam int unsigned RC = 2;
    localparam int unsigned MC = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        cpu_reset, cpu_en, busy, done, pass;
    logic [1:0]  fail_code;
    logic [15:0] cycle_count;
    logic [31:0] last_adr, last_data;

    int vectors = 0;
    int miscompares = 0;

    logic        wr_en  [1:MC];
    logic [31:0] wr_adr [1:MC];
    logic [31:0] wr_dat [1:MC];

    run_controller #(
        .RESET_CYCLES(RC),
        .MAX_CYCLES  (MC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .cycle_count(cycle_count),
        .last_adr   (last_adr),
        .last_data  (last_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, ":cpu_reset"}, cpu_reset, 1'b1);
        chk1({tag, ":cpu_en"}, cpu_en, 1'b0);
        chk1({tag, ":busy"}, busy, 1'b0);
        chk1({tag, ":done"}, done, 1'b0);
        chk1({tag, ":pass"}, pass, 1'b0);
        chk({tag, ":fail_code"}, 32'(fail_code), 32'd0);
        chk({tag, ":cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, ":last_adr"}, last_adr, 32'd0);
        chk({tag, ":last_data"}, last_data, 32'd0);
    endtask

    task automatic clear_prog();
        for (int i = 1; i <= int'(MC); i++) begin
            wr_en[i]  = 1'b0;
            wr_adr[i] = '0;
            wr_dat[i] = '0;
        end
    endtask

    task automatic add_wr(input int n, input logic [31:0] adr, input logic [31:0] dat);
        wr_en[n]  = 1'b1;
        wr_adr[n] = adr;
        wr_dat[n] = dat;
    endtask

    // Reference: first write that is a pass or leaves the scratch word ends the run,
    // otherwise the budget runs out after MC cycles.
    task automatic predict(output int t, output logic p, output logic [1:0] fc,
                           output logic [31:0] la, output logic [31:0] ld);
        bit found = 1'b0;
        t = MC; p = 1'b0; fc = 2'b10; la = '0; ld = '0;
        for (int n = 1; n <= int'(MC); n++) begin
            if (!found && wr_en[n]) begin
                if (wr_adr[n] == 32'd100 && wr_dat[n] == 32'd7) begin
                    t = n; p = 1'b1; fc = 2'b00; la = wr_adr[n]; ld = wr_dat[n]; found = 1'b1;
                end else if (wr_adr[n] != 32'd96) begin
                    t = n; p = 1'b0; fc = 2'b01; la = wr_adr[n]; ld = wr_dat[n]; found = 1'b1;
                end
            end
        end
    endtask

    task automatic run_prog(input string tag, input int abort_at, input bit hold_start);
        int t;
        logic p;
        logic [1:0] fc;
        logic [31:0] la, ld;
        predict(t, p, fc, la, ld);

        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        chk1({tag, ":start busy"}, busy, 1'b1);
        chk1({tag, ":start cpu_reset"}, cpu_reset, 1'b1);
        chk1({tag, ":start done"}, done, 1'b0);
        chk1({tag, ":start pass"}, pass, 1'b0);
        chk({tag, ":start fail_code"}, 32'(fail_code), 32'd0);
        chk({tag, ":start cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, ":start last_adr"}, last_adr, 32'd0);
        chk({tag, ":start last_data"}, last_data, 32'd0);

        // A stray-looking write during the hold window must be ignored.
        MemWrite = 1'b1; DataAdr = 32'h200; WriteData = 32'd1;
        for (int k = 1; k <= int'(RC); k++) begin
            @(posedge clk); #1;
            chk1({tag, ":hold cpu_reset"}, cpu_reset, k < int'(RC));
            chk1({tag, ":hold cpu_en"}, cpu_en, k == int'(RC));
            chk1({tag, ":hold busy"}, busy, 1'b1);
        end

        for (int n = 1; n <= t; n++) begin
            MemWrite = wr_en[n]; DataAdr = wr_adr[n]; WriteData = wr_dat[n];
            @(posedge clk); #1;
            if (n == abort_at) begin
                MemWrite = 1'b0;
                #2 reset = 1'b1;
                #1 check_reset_vals({tag, ":async"});
                #1 reset = 1'b0;
                return;
            end
            if (n < t) begin
                chk({tag, ":run cycle_count"}, 32'(cycle_count), 32'(n));
                chk1({tag, ":run busy"}, busy, 1'b1);
                chk1({tag, ":run cpu_en"}, cpu_en, 1'b1);
                chk1({tag, ":run done"}, done, 1'b0);
            end
        end
        MemWrite = 1'b0;

        chk1({tag, ":end done"}, done, 1'b1);
        chk1({tag, ":end busy"}, busy, 1'b0);
        chk1({tag, ":end cpu_en"}, cpu_en, 1'b0);
        chk1({tag, ":end cpu_reset"}, cpu_reset, 1'b0);
        chk1({tag, ":end pass"}, pass, p);
        chk({tag, ":end fail_code"}, 32'(fail_code), 32'(fc));
        chk({tag, ":end cycle_count"}, 32'(cycle_count), 32'(t));
        chk({tag, ":end last_adr"}, last_adr, la);
        chk({tag, ":end last_data"}, last_data, ld);

        if (hold_start) begin
            @(posedge clk); #1;
            chk1({tag, ":rerun busy"}, busy, 1'b1);
            chk1({tag, ":rerun done"}, done, 1'b0);
            chk1({tag, ":rerun cpu_reset"}, cpu_reset, 1'b1);
            chk({tag, ":rerun cycle_count"}, 32'(cycle_count), 32'd0);
            start = 1'b0;
            reset = 1'b1;
            #1 reset = 1'b0;
        end else begin
            // Writes while frozen must not disturb the verdict.
            MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd8;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                chk1({tag, ":hold done"}, done, 1'b1);
                chk1({tag, ":hold cpu_en"}, cpu_en, 1'b0);
                chk1({tag, ":hold pass"}, pass, p);
                chk({tag, ":hold fail_code"}, 32'(fail_code), 32'(fc));
                chk({tag, ":hold cycle_count"}, 32'(cycle_count), 32'(t));
                chk({tag, ":hold last_data"}, last_data, ld);
            end
            MemWrite = 1'b0;
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Idle: pass-looking writes without start must not release the core.
        for (int i = 0; i < 50; i++) begin
            MemWrite = i[0]; DataAdr = 32'd100; WriteData = 32'd7;
            @(posedge clk); #1;
            chk1("idle cpu_reset", cpu_reset, 1'b1);
            chk1("idle cpu_en", cpu_en, 1'b0);
            chk1("idle done", done, 1'b0);
        end
        MemWrite = 1'b0;

        clear_prog();
        add_wr(5, 32'd96, $urandom);
        add_wr(9, 32'd96, $urandom);
        add_wr(15, 32'd100, 32'd7);
        run_prog("pass", 0, 1'b0);

        clear_prog();
        add_wr(4, 32'd100, 32'd8);
        run_prog("stray", 0, 1'b0);

        clear_prog();
        run_prog("timeout", 0, 1'b0);

        clear_prog();
        add_wr(20, 32'd100, 32'd7);
        run_prog("simul", 0, 1'b0);

        clear_prog();
        run_prog("abort", 7, 1'b0);

        clear_prog();
        add_wr(3, 32'd100, 32'd7);
        run_prog("restart", 0, 1'b0);

        clear_prog();
        add_wr(2, 32'd96, 32'd5);
        add_wr(11, 32'h0000_0300, 32'd5);
        run_prog("again", 0, 1'b0);

        clear_prog();
        add_wr(6, 32'h0000_0300, 32'd5);
        run_prog("held", 0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            int unsigned prob;
            clear_prog();
            prob = $urandom_range(0, 30);
            for (int n = 1; n <= int'(MC); n++) begin
                if ($urandom_range(0, 99) < prob) begin
                    int unsigned sel;
                    logic [31:0] a, d;
                    sel = $urandom_range(0, 9);
                    d = $urandom;
                    if (sel <= 5) begin
                        a = 32'd96;
                    end else if (sel <= 7) begin
                        a = 32'd100; d = 32'd7;
                    end else if (sel == 8) begin
                        a = 32'd100;
                        if (d == 32'd7) d = 32'd8;
                    end else begin
                        a = $urandom;
                        if (a == 32'd96) a = 32'd97;
                    end
                    add_wr(n, a, d);
                end
            end
            run_prog("rand", 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Run controller for the single-cycle processor `top`. It holds the core in reset, releases it on `start`, and clock-enables it for a bounded run. While the core runs, it monitors the data-memory write port (`MemWrite`, `DataAdr`, `WriteData`). It ends the run with a pass, stray-write or timeout verdict, so program sequencing and self-checking live in hardware rather than in the bench.

## Interface
Parameters:
- `RESET_CYCLES`, 2: number of cycles the core reset is held after `start`; must be ≥1.
- `MAX_CYCLES`, 1000: RUN-cycle budget before timeout; must be ≥1 and < 2^CNT_W.
- `CNT_W`, 16: width of `cycle_count`.
- `PASS_ADR`, 32'd100: address of the pass write.
- `PASS_DATA`, 32'd7: data of the pass write.
- `SCRATCH_ADR`, 32'd96: the only address the program may write to without ending the run.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: level-sampled; starts a run from IDLE or DONE.
- `MemWrite`  in  1: core data-memory write strobe.
- `DataAdr`  in  32: core data-memory address.
- `WriteData`  in  32: core store data.
- `cpu_reset`  out  1: reset to `top`.
- `cpu_en`  out  1: clock enable to `top`; gates PC and register-file/memory updates.
- `busy`  out  1: high in HOLD or RUN.
- `done`  out  1: high in DONE.
- `pass`  out  1: verdict, valid while `done`.
- `fail_code`  out  2: 00 none/pass, 01 stray write, 10 timeout.
- `cycle_count`  out  CNT_W: number of RUN cycles completed.
- `last_adr`  out  32: `DataAdr` of the terminating write.
- `last_data`  out  32: `WriteData` of the terminating write.

## Operation
- FSM states: IDLE, HOLD, RUN, DONE. All outputs are registered.
- Reset values:
  - state = IDLE, `cpu_reset` = 1, `cpu_en` = 0.
  - `busy`, `done`, `pass` = 0.
  - `fail_code` = 0, `cycle_count` = 0, `last_adr` = 0, `last_data` = 0.
- IDLE:
  - `cpu_reset` = 1, `cpu_en` = 0.
  - `start` = 1 → HOLD. Clear `cycle_count`, the verdicts and the `last_*` registers.
- HOLD:
  - `cpu_reset` = 1; an internal hold counter counts RESET_CYCLES edges.
  - On the last edge, go to RUN: `cpu_reset` = 0 and `cpu_en` = 1 on the same edge.
  - `start` is ignored.
- RUN, evaluated on every edge:
  - `cycle_count` increments.
  - Evaluate in this priority order:
    1. `MemWrite` with `DataAdr` == PASS_ADR and `WriteData` == PASS_DATA → DONE, `pass` = 1, `fail_code` = 00.
    2. `MemWrite` with `DataAdr` != SCRATCH_ADR (this includes PASS_ADR with wrong data) → DONE, `pass` = 0, `fail_code` = 01.
    3. `cycle_count` + 1 == MAX_CYCLES → DONE, `fail_code` = 10.
  - Otherwise stay in RUN.
  - Writes to SCRATCH_ADR never terminate the run.
  - `last_adr` and `last_data` are captured only on terminations 1 and 2.
  - `start` is ignored.
- DONE:
  - `cpu_en` = 0 (core frozen), `cpu_reset` = 0, `done` = 1.
  - Verdict, `cycle_count` and `last_*` hold.
  - `start` → HOLD: clear everything as in IDLE; `cpu_reset` rises on that edge.
- `MemWrite` is ignored outside RUN.
- `cycle_count` never exceeds MAX_CYCLES; no wrap-around.

## Timing
- `start` sampled high at edge E0 in IDLE:
  - `busy` = 1 after E0.
  - `cpu_reset` falls and `cpu_en` rises after edge E0+RESET_CYCLES.
- RUN edge n (first RUN edge is n = 1):
  - `cycle_count` = n after that edge.
  - The write port is sampled at the same edge the core commits its store.
- Termination: `done` rises and `busy` and `cpu_en` fall after the edge on which the terminating condition is sampled. The core executes no further edges.
- Simultaneous pass write and timeout on the same edge: pass wins, `cycle_count` = MAX_CYCLES.
- Asynchronous `reset` in any state, including mid-RUN: all outputs immediately take their reset values, and `cpu_reset` asserts without waiting for `clk`.
- `start` held high continuously: a new run begins on the first edge in DONE.

## Test plan
- Idle after reset:
  - Stimulus: deassert `reset`, keep `start` = 0, pulse `MemWrite` with `DataAdr` = 100, `WriteData` = 7.
  - Required: `cpu_reset` = 1, `cpu_en` = 0, `done` = 0 for 50 cycles.
- Pass run (RESET_CYCLES = 2):
  - Stimulus: `start` at E0; scratch writes to 96 on RUN cycles 5 and 9; write 100/7 on RUN cycle 15.
  - Required: `cpu_reset` falls after E0+2; `done` = 1, `pass` = 1, `fail_code` = 00, `cycle_count` = 15, `last_adr` = 100, `last_data` = 7.
- Stray write:
  - Stimulus: write `DataAdr` = 100, `WriteData` = 8 on RUN cycle 4.
  - Required: `done` = 1, `pass` = 0, `fail_code` = 01, `last_data` = 8, `cycle_count` = 4, `cpu_en` = 0.
- Timeout (MAX_CYCLES = 20):
  - Stimulus: no writes.
  - Required: `done` after RUN cycle 20, `fail_code` = 10, `cycle_count` = 20, `last_adr` = 0.
- Simultaneous events (MAX_CYCLES = 20):
  - Stimulus: write 100/7 on RUN cycle 20.
  - Required: `pass` = 1, `fail_code` = 00.
- Reset mid-run and restart:
  - Stimulus: assert `reset` between edges at RUN cycle 7; then `start`, then a pass write on RUN cycle 3.
  - Required: outputs at reset values with no clock edge needed; the new run passes with `cycle_count` = 3.
  - Follow-up: a second `start` from DONE clears `done` and reasserts `cpu_reset`.
